// File: rtl/fifo_rd_ctrl.sv
// Read-domain controller for the async FIFO: read pointer, EMPTY/LEVEL, 1-cycle memory read sequencing.
// Output register plus a one-entry skid buffer sustain 1 word/cycle and hold data losslessly under backpressure.
module fifo_rd_ctrl #(
    parameter int ADDRESS_BITS = 3,
    parameter int DATA_WIDTH   = 8
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [ADDRESS_BITS:0]   RQ2_WPTR,
    output logic [ADDRESS_BITS:0]   R_PTR,
    output logic                    R_EN,
    output logic [ADDRESS_BITS-1:0] R_ADDR,
    input  logic [DATA_WIDTH-1:0]   RD_DATA,
    output logic [DATA_WIDTH-1:0]   OUT_DATA,
    output logic                    OUT_VALID,
    input  logic                    OUT_READY,
    output logic                    EMPTY,
    output logic [ADDRESS_BITS:0]   LEVEL
);

    localparam int PW = ADDRESS_BITS + 1;

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [PW-1:0]         rbin_q, rbin_d;
    logic [PW-1:0]         rptr_q, rptr_d;
    logic                  inflight_q, inflight_d;
    logic                  out_vld_q, out_vld_d;
    logic [DATA_WIDTH-1:0] out_dat_q, out_dat_d;
    logic                  skid_vld_q, skid_vld_d;
    logic [DATA_WIDTH-1:0] skid_dat_q, skid_dat_d;

    logic       pop;
    logic [1:0] occ;
    logic [1:0] occ_after_pop;
    logic       empty;
    logic       r_en;

    assign empty         = (rptr_q == RQ2_WPTR);
    assign pop           = out_vld_q & OUT_READY;
    assign occ           = {1'b0, out_vld_q} + {1'b0, skid_vld_q} + {1'b0, inflight_q};
    assign occ_after_pop = occ - {1'b0, pop};
    // At most two words may be buffered or in flight once this cycle's pop is accounted for.
    assign r_en          = !empty && (occ_after_pop <= 2'd1);

    assign EMPTY     = empty;
    assign LEVEL     = gray2bin(RQ2_WPTR) - rbin_q;
    assign R_EN      = r_en;
    assign R_ADDR    = rbin_q[ADDRESS_BITS-1:0];
    assign R_PTR     = rptr_q;
    assign OUT_VALID = out_vld_q;
    assign OUT_DATA  = out_dat_q;

    always_comb begin
        rbin_d     = rbin_q + PW'(r_en);
        rptr_d     = rbin_d ^ (rbin_d >> 1);
        inflight_d = r_en;
        out_vld_d  = out_vld_q;
        out_dat_d  = out_dat_q;
        skid_vld_d = skid_vld_q;
        skid_dat_d = skid_dat_q;

        // Oldest word first: skid, then landing read data, so ordering is preserved.
        if (skid_vld_q && (pop || !out_vld_q)) begin
            out_vld_d  = 1'b1;
            out_dat_d  = skid_dat_q;
            skid_vld_d = inflight_q;
            if (inflight_q) begin
                skid_dat_d = RD_DATA;
            end
        end else if (!out_vld_q || pop) begin
            out_vld_d = inflight_q;
            if (inflight_q) begin
                out_dat_d = RD_DATA;
            end
        end else if (inflight_q) begin
            skid_vld_d = 1'b1;
            skid_dat_d = RD_DATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rbin_q     <= '0;
            rptr_q     <= '0;
            inflight_q <= 1'b0;
            out_vld_q  <= 1'b0;
            out_dat_q  <= '0;
            skid_vld_q <= 1'b0;
            skid_dat_q <= '0;
        end else begin
            rbin_q     <= rbin_d;
            rptr_q     <= rptr_d;
            inflight_q <= inflight_d;
            out_vld_q  <= out_vld_d;
            out_dat_q  <= out_dat_d;
            skid_vld_q <= skid_vld_d;
            skid_dat_q <= skid_dat_d;
        end
    end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: bench-side write side and memory, scoreboard of expected words in write order.
module tb_fifo_rd_ctrl;

    logic       CLK = 1'b0;
    logic       RST;
    logic [3:0] RQ2_WPTR;
    logic [3:0] R_PTR;
    logic       R_EN;
    logic [2:0] R_ADDR;
    logic [7:0] RD_DATA;
    logic [7:0] OUT_DATA;
    logic       OUT_VALID;
    logic       OUT_READY;
    logic       EMPTY;
    logic [3:0] LEVEL;

    fifo_rd_ctrl #(.ADDRESS_BITS(3), .DATA_WIDTH(8)) dut (
        .CLK(CLK), .RST(RST), .RQ2_WPTR(RQ2_WPTR), .R_PTR(R_PTR), .R_EN(R_EN),
        .R_ADDR(R_ADDR), .RD_DATA(RD_DATA), .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID),
        .OUT_READY(OUT_READY), .EMPTY(EMPTY), .LEVEL(LEVEL)
    );

    always #5 CLK = ~CLK;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] mem [8];
    logic [7:0] expq [$];
    logic [3:0] wbin;
    logic [2:0] raddr_m;
    int         occ_m;
    int         pop_cnt = 0;
    logic       prev_hold;
    logic [7:0] prev_dat;

    function automatic logic [3:0] to_gray(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    // Memory with one-cycle read latency.
    always @(posedge CLK) begin
        if (R_EN === 1'b1) RD_DATA <= mem[R_ADDR];
    end

    always @(negedge CLK) begin
        if (RST) begin
            expq.delete();
            raddr_m   = 3'd0;
            occ_m     = 0;
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                checks++;
                if (OUT_VALID !== 1'b1 || OUT_DATA !== prev_dat) begin
                    errors++;
                    $display("FAIL hold_stable: got vld=%b dat=%h, need vld=1 dat=%h", OUT_VALID, OUT_DATA, prev_dat);
                end
            end
            if (R_EN === 1'b1) begin
                checks++;
                if (R_ADDR !== raddr_m) begin
                    errors++;
                    $display("FAIL r_addr: got %0d, need %0d", R_ADDR, raddr_m);
                end
                raddr_m = raddr_m + 3'd1;
            end
            if (OUT_VALID === 1'b1) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_word: got %h, need no valid word", OUT_DATA);
                end else if (OUT_READY) begin
                    logic [7:0] exp_w;
                    exp_w = expq.pop_front();
                    pop_cnt++;
                    if (OUT_DATA !== exp_w) begin
                        errors++;
                        $display("FAIL out_data: got %h, need %h", OUT_DATA, exp_w);
                    end
                end
            end
            occ_m = occ_m + ((R_EN === 1'b1) ? 1 : 0) - ((OUT_VALID === 1'b1 && OUT_READY) ? 1 : 0);
            checks++;
            if (occ_m > 2 || occ_m < 0) begin
                errors++;
                $display("FAIL occupancy: got %0d, need 0..2", occ_m);
            end
            prev_hold = (OUT_VALID === 1'b1) && !OUT_READY;
            prev_dat  = OUT_DATA;
        end
    end

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_word(input logic [7:0] d);
        mem[wbin[2:0]] = d;
        expq.push_back(d);
        wbin     = wbin + 4'd1;
        RQ2_WPTR = to_gray(wbin);
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while (expq.size() != 0 && n < budget) begin
            @(posedge CLK);
            n++;
        end
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: got %0d words left, need 0", name, expq.size());
        end
    endtask

    task automatic test_reset();
        RST = 1'b1; wbin = 4'd0; RQ2_WPTR = 4'd0; OUT_READY = 1'b0; RD_DATA = 8'd0;
        repeat (2) @(posedge CLK);
        for (int c = 0; c < 2; c++) begin
            @(negedge CLK);
            checks++;
            if (R_PTR !== 4'd0 || OUT_VALID !== 1'b0 || OUT_DATA !== 8'd0 || EMPTY !== 1'b1 ||
                LEVEL !== 4'd0 || R_EN !== 1'b0) begin
                errors++;
                $display("FAIL reset_state%0d: got ptr=%b vld=%b dat=%h empty=%b lvl=%0d ren=%b, need 0 0 00 1 0 0",
                         c, R_PTR, OUT_VALID, OUT_DATA, EMPTY, LEVEL, R_EN);
            end
            next_cycle();
            RST = 1'b0;
        end
    endtask

    task automatic test_streaming();
        next_cycle();
        OUT_READY = 1'b1;
        for (int i = 0; i < 4; i++) push_word(8'hA0 + 8'(i));
        for (int c = 0; c < 6; c++) begin
            @(negedge CLK);
            checks++;
            if (R_EN !== (c < 4) || OUT_VALID !== (c >= 2)) begin
                errors++;
                $display("FAIL stream_cycle%0d: got ren=%b vld=%b, need ren=%b vld=%b", c, R_EN, OUT_VALID, c < 4, c >= 2);
            end
            if (c >= 2) begin
                checks++;
                if (OUT_DATA !== 8'hA0 + 8'(c - 2)) begin
                    errors++;
                    $display("FAIL stream_data%0d: got %h, need %h", c, OUT_DATA, 8'hA0 + 8'(c - 2));
                end
            end
        end
        checks++;
        if (R_PTR !== 4'b0110 || EMPTY !== 1'b1) begin
            errors++;
            $display("FAIL stream_end: got ptr=%b empty=%b, need ptr=0110 empty=1", R_PTR, EMPTY);
        end
        drain("stream", 10);
    endtask

    task automatic test_backpressure();
        int ren_cnt = 0;
        next_cycle();
        OUT_READY = 1'b0;
        for (int i = 0; i < 4; i++) push_word(8'hA0 + 8'(i));
        for (int c = 0; c < 6; c++) begin
            @(negedge CLK);
            if (R_EN === 1'b1) ren_cnt++;
        end
        checks++;
        if (ren_cnt != 2) begin
            errors++;
            $display("FAIL bp_reads: got %0d, need 2", ren_cnt);
        end
        checks++;
        if (OUT_VALID !== 1'b1 || OUT_DATA !== 8'hA0 || LEVEL !== 4'd2) begin
            errors++;
            $display("FAIL bp_state: got vld=%b dat=%h lvl=%0d, need 1 a0 2", OUT_VALID, OUT_DATA, LEVEL);
        end
        next_cycle();
        OUT_READY = 1'b1;
        drain("bp", 20);
    endtask

    task automatic test_wrap();
        int   pops0 = pop_cnt;
        logic seen_zero = 1'b0;
        logic addr_wrap = 1'b0;
        logic [2:0] last_addr = 3'd0;
        OUT_READY = 1'b1;
        for (int w = 0; w < 20; w++) begin
            next_cycle();
            push_word(8'($urandom));
            for (int h = 0; h < 2; h++) begin
                @(negedge CLK);
                if (R_PTR === 4'b0000) seen_zero = 1'b1;
                if (R_EN === 1'b1) begin
                    if (last_addr == 3'd7 && R_ADDR === 3'd0) addr_wrap = 1'b1;
                    last_addr = R_ADDR;
                end
                if (h == 0) next_cycle();
            end
        end
        drain("wrap", 20);
        @(negedge CLK);
        checks++;
        if (!seen_zero || !addr_wrap || R_PTR !== 4'b1010 || pop_cnt - pops0 != 20) begin
            errors++;
            $display("FAIL wrap: got zero=%b awrap=%b ptr=%b words=%0d, need 1 1 1010 20",
                     seen_zero, addr_wrap, R_PTR, pop_cnt - pops0);
        end
    endtask

    task automatic test_random_stall();
        int n = 0;
        next_cycle();
        for (int i = 0; i < 8; i++) push_word(8'($urandom));
        while (expq.size() != 0 && n < 300) begin
            OUT_READY = 1'($urandom_range(0, 1));
            next_cycle();
            n++;
        end
        OUT_READY = 1'b1;
        drain("stall", 10);
    endtask

    task automatic test_mid_reset();
        next_cycle();
        OUT_READY = 1'b0;
        for (int i = 0; i < 4; i++) push_word(8'hC0 + 8'(i));
        for (int c = 0; c < 2; c++) begin
            @(negedge CLK);
            checks++;
            if (R_EN !== 1'b1) begin
                errors++;
                $display("FAIL mid_rst_read%0d: got ren=%b, need 1", c, R_EN);
            end
        end
        next_cycle();
        RST = 1'b1; wbin = 4'd0; RQ2_WPTR = 4'd0;
        @(negedge CLK);
        checks++;
        if (OUT_VALID !== 1'b1) begin
            errors++;
            $display("FAIL mid_rst_pre: got vld=%b, need 1", OUT_VALID);
        end
        next_cycle();
        RST = 1'b0;
        OUT_READY = 1'b1;
        @(negedge CLK);
        checks++;
        if (OUT_VALID !== 1'b0 || R_PTR !== 4'd0 || OUT_DATA !== 8'd0) begin
            errors++;
            $display("FAIL mid_rst_post: got vld=%b ptr=%b dat=%h, need 0 0000 00", OUT_VALID, R_PTR, OUT_DATA);
        end
        repeat (4) next_cycle();
        for (int i = 0; i < 3; i++) push_word(8'h50 + 8'(i));
        drain("mid_rst", 15);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, need completion");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_wrap();
        test_random_stall();
        test_mid_reset();
        repeat (2) @(posedge CLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
